control_muestreo_adc: RTL and testbench

- Sequencing controller for the serial ADC front end.
- Generates the ADC chip-select and serial clock, and shifts in one F-bit sample per sample period.
- Presents each sample, held stable, to the downstream truncation/offset stage, which latches on the falling edge of cs_n.
- The stage therefore captures the previous frame's sample at the start of each new conversion.

---
 rtl/control_muestreo_adc_pkg.sv | 22 ++
 rtl/control_muestreo_adc_gen_tick.sv | 37 +++
 rtl/control_muestreo_adc.sv | 172 +++++++++++++++++
 tb/tb_control_muestreo_adc.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/control_muestreo_adc_pkg.sv
// Shared constants and types for the serial ADC sampling controller.
// Optional feature macro: SATURACION_EN (adds the sat output).
package control_muestreo_adc_pkg;

    localparam int unsigned F_ADC           = 12;
    localparam int unsigned FRAME_ADC       = 16;
    localparam int unsigned DIV_SCLK        = 2;
    localparam int unsigned QUIET_CS        = 3;
    localparam int unsigned PERIODO_MUESTRA = 1134;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CONV  = 2'd1,
        ST_QUIET = 2'd2
    } estado_t;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/control_muestreo_adc_gen_tick.sv
// Modulo-N counter with enable and synchronous clear; tick_c marks the last count.
module control_muestreo_adc_gen_tick
    import control_muestreo_adc_pkg::*;
#(
    parameter int unsigned N = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick_c
);

    localparam int unsigned W = cnt_width(N);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d  = cnt_q;
        tick_c = en && !clr && (cnt_q == W'(N - 1));
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tick_c ? '0 : cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/control_muestreo_adc.sv
// Serial ADC sequencer: cs_n/sclk generation, MSB-first capture, held sample output.
// Optional feature macro: SATURACION_EN (adds the registered sat flag).
module control_muestreo_adc
    import control_muestreo_adc_pkg::*;
#(
    parameter int unsigned F      = F_ADC,
    parameter int unsigned DIV    = DIV_SCLK,
    parameter int unsigned FRAME  = FRAME_ADC,
    parameter int unsigned QUIET  = QUIET_CS,
    parameter int unsigned PERIOD = PERIODO_MUESTRA
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         sdata,
    output logic         cs_n,
    output logic         sclk,
    output logic [F-1:0] dato,
    output logic         dato_valid,
`ifdef SATURACION_EN
    output logic         overrun,
    output logic         sat
`else
    output logic         overrun
`endif
);

    localparam int unsigned BW = cnt_width(FRAME);
    localparam int unsigned QW = cnt_width(QUIET);

    estado_t       estado_q, estado_d;
    logic          cs_n_q, cs_n_d;
    logic          sclk_q, sclk_d;
    logic [F-1:0]  shift_q, shift_d;
    logic [BW-1:0] bit_q, bit_d;
    logic [QW-1:0] quiet_q, quiet_d;
    logic [F-1:0]  dato_q, dato_d;
    logic          valid_q, valid_d;
    logic          ovr_q, ovr_d;
`ifdef SATURACION_EN
    logic          sat_q, sat_d;
`endif

    logic          tick_periodo;
    logic          strobe;
    logic          en_div;
    logic [F-1:0]  shift_nxt;

    assign en_div    = (estado_q == ST_CONV);
    assign shift_nxt = {shift_q[F-2:0], sdata};

    control_muestreo_adc_gen_tick #(.N(PERIOD)) u_tick_periodo (
        .clk    (clk),
        .reset  (reset),
        .en     (en),
        .clr    (!en),
        .tick_c (tick_periodo)
    );

    control_muestreo_adc_gen_tick #(.N(DIV)) u_tick_sclk (
        .clk    (clk),
        .reset  (reset),
        .en     (en_div),
        .clr    (!en_div),
        .tick_c (strobe)
    );

    always_comb begin
        estado_d = estado_q;
        cs_n_d   = cs_n_q;
        sclk_d   = sclk_q;
        shift_d  = shift_q;
        bit_d    = bit_q;
        quiet_d  = quiet_q;
        dato_d   = dato_q;
        valid_d  = 1'b0;
        ovr_d    = tick_periodo && (estado_q != ST_IDLE);
`ifdef SATURACION_EN
        sat_d    = sat_q;
`endif
        case (estado_q)
            ST_IDLE: begin
                cs_n_d  = 1'b1;
                sclk_d  = 1'b1;
                bit_d   = '0;
                quiet_d = '0;
                if (tick_periodo) begin
                    estado_d = ST_CONV;
                    cs_n_d   = 1'b0;
                    shift_d  = '0;
                end
            end
            ST_CONV: begin
                if (strobe) begin
                    sclk_d = !sclk_q;
                    // sclk rising edge: capture, and close the frame on the last one
                    if (!sclk_q) begin
                        shift_d = shift_nxt;
                        if (bit_q == BW'(FRAME - 1)) begin
                            estado_d = ST_QUIET;
                            cs_n_d   = 1'b1;
                            sclk_d   = 1'b1;
                            bit_d    = '0;
                            dato_d   = shift_nxt;
                            valid_d  = 1'b1;
`ifdef SATURACION_EN
                            sat_d    = (shift_nxt == '0) || (shift_nxt == '1);
`endif
                        end else begin
                            bit_d = bit_q + BW'(1);
                        end
                    end
                end
            end
            ST_QUIET: begin
                cs_n_d = 1'b1;
                sclk_d = 1'b1;
                if (quiet_q == QW'(QUIET - 1)) begin
                    estado_d = ST_IDLE;
                    quiet_d  = '0;
                end else begin
                    quiet_d = quiet_q + QW'(1);
                end
            end
            default: begin
                estado_d = ST_IDLE;
                cs_n_d   = 1'b1;
                sclk_d   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q <= ST_IDLE;
            cs_n_q   <= 1'b1;
            sclk_q   <= 1'b1;
            shift_q  <= '0;
            bit_q    <= '0;
            quiet_q  <= '0;
            dato_q   <= '0;
            valid_q  <= 1'b0;
            ovr_q    <= 1'b0;
`ifdef SATURACION_EN
            sat_q    <= 1'b0;
`endif
        end else begin
            estado_q <= estado_d;
            cs_n_q   <= cs_n_d;
            sclk_q   <= sclk_d;
            shift_q  <= shift_d;
            bit_q    <= bit_d;
            quiet_q  <= quiet_d;
            dato_q   <= dato_d;
            valid_q  <= valid_d;
            ovr_q    <= ovr_d;
`ifdef SATURACION_EN
            sat_q    <= sat_d;
`endif
        end
    end

    assign cs_n       = cs_n_q;
    assign sclk       = sclk_q;
    assign dato       = dato_q;
    assign dato_valid = valid_q;
    assign overrun    = ovr_q;
`ifdef SATURACION_EN
    assign sat        = sat_q;
`endif

endmodule

// File: tb/tb_control_muestreo_adc.sv
// Directed bench: default-period instance A and a fast-period (PERIOD=40) instance B.
module tb_control_muestreo_adc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic        reset_a = 1'b1, en_a = 1'b0, sdata_a = 1'b0;
    logic        cs_n_a, sclk_a, dv_a, ovr_a;
    logic [11:0] dato_a;
    logic        reset_b = 1'b1, en_b = 1'b0, sdata_b = 1'b0;
    logic        cs_n_b, sclk_b, dv_b, ovr_b;
    logic [11:0] dato_b;
`ifdef SATURACION_EN
    logic        sat_a, sat_b;
`endif

    control_muestreo_adc dut_a (
        .clk        (clk),
        .reset      (reset_a),
        .en         (en_a),
        .sdata      (sdata_a),
        .cs_n       (cs_n_a),
        .sclk       (sclk_a),
        .dato       (dato_a),
        .dato_valid (dv_a),
`ifdef SATURACION_EN
        .overrun    (ovr_a),
        .sat        (sat_a)
`else
        .overrun    (ovr_a)
`endif
    );

    control_muestreo_adc #(.PERIOD(40)) dut_b (
        .clk        (clk),
        .reset      (reset_b),
        .en         (en_b),
        .sdata      (sdata_b),
        .cs_n       (cs_n_b),
        .sclk       (sclk_b),
        .dato       (dato_b),
        .dato_valid (dv_b),
`ifdef SATURACION_EN
        .overrun    (ovr_b),
        .sat        (sat_b)
`else
        .overrun    (ovr_b)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    // ADC models: new word on cs_n fall, one bit per sclk fall, MSB first
    logic [15:0] words_a [8];
    logic [15:0] words_b [8];
    logic [15:0] wa, wb;
    int fa = 0, ia = 0, fb = 0, ib = 0;

    always @(negedge cs_n_a or negedge sclk_a) begin
        if (cs_n_a == 1'b0) begin
            if (sclk_a == 1'b1) begin
                wa = (fa < 8) ? words_a[fa] : 16'h0;
                fa++;
                ia = 0;
            end else if (ia < 16) begin
                sdata_a = wa[15-ia];
                ia++;
            end
        end
    end

    always @(negedge cs_n_b or negedge sclk_b) begin
        if (cs_n_b == 1'b0) begin
            if (sclk_b == 1'b1) begin
                wb = (fb < 8) ? words_b[fb] : 16'h0;
                fb++;
                ib = 0;
            end else if (ib < 16) begin
                sdata_b = wb[15-ib];
                ib++;
            end
        end
    end

    int a_cyc = 0, a_falls = 0, a_rises = 0, a_valids = 0, a_ovr = 0;
    int a_fall_cyc [16];
    int a_valid_cyc [16];
    logic [11:0] a_dato [16];
    logic a_cs_prev = 1'b1, a_sclk_prev = 1'b1;

    always @(negedge clk) begin
        a_cyc++;
        if (a_cs_prev && !cs_n_a) begin
            if (a_falls < 16) a_fall_cyc[a_falls] = a_cyc;
            a_falls++;
        end
        if (!a_sclk_prev && sclk_a) a_rises++;
        if (dv_a) begin
            if (a_valids < 16) begin
                a_valid_cyc[a_valids] = a_cyc;
                a_dato[a_valids]      = dato_a;
            end
            a_valids++;
        end
        if (ovr_a) a_ovr++;
        a_cs_prev   = cs_n_a;
        a_sclk_prev = sclk_a;
    end

    int b_cyc = 0, b_falls = 0, b_rises = 0, b_valids = 0, b_ovr = 0;
    int b_high_run = 0, b_min_high = 100000;
    int b_fall_cyc [16];
    logic [11:0] b_dato [16];
    logic b_sat [16];
    logic b_cs_prev = 1'b1, b_sclk_prev = 1'b1;

    always @(negedge clk) begin
        b_cyc++;
        if (b_cs_prev && !cs_n_b) begin
            if (b_falls < 16) b_fall_cyc[b_falls] = b_cyc;
            b_falls++;
            if (b_falls > 1 && b_high_run < b_min_high) b_min_high = b_high_run;
            b_high_run = 0;
        end
        if (cs_n_b === 1'b1) b_high_run++;
        if (!b_sclk_prev && sclk_b) b_rises++;
        if (dv_b) begin
            if (b_valids < 16) begin
                b_dato[b_valids] = dato_b;
`ifdef SATURACION_EN
                b_sat[b_valids]  = sat_b;
`else
                b_sat[b_valids]  = 1'b0;
`endif
            end
            b_valids++;
        end
        if (ovr_b) b_ovr++;
        b_cs_prev   = cs_n_b;
        b_sclk_prev = sclk_b;
    end

    task automatic run_a();
        int base;
        reset_a = 1'b1;
        en_a    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(1);
            check_eq("a_reset_hold", 32'({cs_n_a, sclk_a, dv_a, ovr_a, dato_a}), 32'h0000_C000);
        end
        reset_a = 1'b0;
        step(3 * 1134 + 100);
        check_eq("a_falls_3p", a_falls, 3);
        check_eq("a_period_1", a_fall_cyc[1] - a_fall_cyc[0], 1134);
        check_eq("a_period_2", a_fall_cyc[2] - a_fall_cyc[1], 1134);
        check_eq("a_latency", a_valid_cyc[0] - a_fall_cyc[0], 64);
        check_eq("a_valids_3p", a_valids, 3);
        check_eq("a_dato_0", 32'(a_dato[0]), 32'h0A53);
        check_eq("a_dato_1", 32'(a_dato[1]), 32'h05C3);
        check_eq("a_dato_2", 32'(a_dato[2]), 32'h0001);
        check_eq("a_rises_3p", a_rises, 48);
        check_eq("a_no_overrun", a_ovr, 0);
        check_eq("a_dato_held", 32'(dato_a), 32'h0001);

        // en dropped after 10 sclk rising edges of the fourth frame
        for (int i = 0; i < 1300 && a_falls < 4; i++) step(1);
        check_eq("a_frame4_start", a_falls, 4);
        base = a_rises;
        for (int i = 0; i < 100 && a_rises < base + 10; i++) step(1);
        check_eq("a_frame4_10rises", a_rises - base, 10);
        en_a = 1'b0;
        step(1300);
        check_eq("a_endrop_valids", a_valids, 4);
        check_eq("a_endrop_dato", 32'(a_dato[3]), 32'h0234);
        check_eq("a_endrop_nofall", a_falls, 4);
        check_eq("a_endrop_cs_idle", 32'({cs_n_a, sclk_a}), 32'h3);

        // reset after 10 sclk rising edges of the fifth frame
        en_a = 1'b1;
        for (int i = 0; i < 1300 && a_falls < 5; i++) step(1);
        check_eq("a_frame5_start", a_falls, 5);
        base = a_rises;
        for (int i = 0; i < 100 && a_rises < base + 10; i++) step(1);
        reset_a = 1'b1;
        step(1);
        check_eq("a_midreset_pins", 32'({cs_n_a, sclk_a}), 32'h3);
        check_eq("a_midreset_dato", 32'(dato_a), 32'h0);
        check_eq("a_midreset_novalid", a_valids, 4);
        reset_a = 1'b0;
        step(2);
    endtask

    task automatic run_b();
        reset_b = 1'b1;
        en_b    = 1'b1;
        step(2);
        reset_b = 1'b0;
        for (int i = 0; i < 400 && b_valids < 3; i++) step(1);
        en_b = 1'b0;
        step(200);
        check_eq("b_valids", b_valids, 3);
        check_eq("b_falls", b_falls, 3);
        check_eq("b_overrun_cnt", b_ovr, 3);
        check_eq("b_rises", b_rises, 48);
        check_eq("b_spacing", b_fall_cyc[1] - b_fall_cyc[0], 80);
        check_eq("b_min_cs_high", 32'(b_min_high >= 3), 32'h1);
        check_eq("b_dato_0", 32'(b_dato[0]), 32'h0FFF);
        check_eq("b_dato_1", 32'(b_dato[1]), 32'h0000);
        check_eq("b_dato_2", 32'(b_dato[2]), 32'h07FF);
`ifdef SATURACION_EN
        check_eq("b_sat_0", 32'(b_sat[0]), 32'h1);
        check_eq("b_sat_1", 32'(b_sat[1]), 32'h1);
        check_eq("b_sat_2", 32'(b_sat[2]), 32'h0);
`endif
    endtask

    initial begin
        words_a[0] = 16'h0A53;
        words_a[1] = 16'hF5C3;
        words_a[2] = 16'h8001;
        words_a[3] = 16'h1234;
        words_a[4] = 16'hFFFF;
        words_a[5] = 16'h0000;
        words_a[6] = 16'h0000;
        words_a[7] = 16'h0000;
        words_b[0] = 16'h0FFF;
        words_b[1] = 16'hF000;
        words_b[2] = 16'h07FF;
        words_b[3] = 16'h0A53;
        words_b[4] = 16'h0000;
        words_b[5] = 16'h0000;
        words_b[6] = 16'h0000;
        words_b[7] = 16'h0000;
        fork
            run_a();
            run_b();
        join
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
